// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared mode encoding, blank constants and field-blank helper for the display scheduler
package disp_pkg;

  typedef enum logic [2:0] {
    MODE_TIME   = 3'd0,
    MODE_DATE   = 3'd1,
    MODE_ALARM  = 3'd2,
    MODE_SWATCH = 3'd3,
    MODE_RING   = 3'd4
  } mode_t;

  localparam logic [3:0]  BLANK_NIBBLE = 4'hF;
  localparam logic [23:0] BLANK_ALL    = 24'hFFFFFF;
  localparam logic [1:0]  FIELD_NONE   = 2'd3;

  // Force both digits of the selected two-digit field to the blank code.
  function automatic logic [23:0] blank_field(input logic [23:0] value, input logic [1:0] field);
    logic [23:0] res;
    res = value;
    case (field)
      2'd0:    res[7:0]   = {BLANK_NIBBLE, BLANK_NIBBLE};
      2'd1:    res[15:8]  = {BLANK_NIBBLE, BLANK_NIBBLE};
      2'd2:    res[23:16] = {BLANK_NIBBLE, BLANK_NIBBLE};
      default: res        = value;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// rtl/disp_tick_gen.sv - blink half-period counter with phase flag and saturating idle timer
module disp_tick_gen #(
  parameter int unsigned BLINK_HALF_MS   = 250,
  parameter int unsigned IDLE_TIMEOUT_MS = 10000
) (
  input  logic clk1khz,
  input  logic rst_n,
  input  logic blink_clr,
  input  logic idle_clr,
  output logic blink_phase,
  output logic idle_max
);

  localparam int unsigned BW = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;
  localparam int unsigned IW = (IDLE_TIMEOUT_MS > 1) ? $clog2(IDLE_TIMEOUT_MS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_MS - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT_MS - 1);

  logic [BW-1:0] blink_cnt;
  logic [IW-1:0] idle_cnt;

  // Blink counter: restart in the visible half on clear, toggle phase at each wrap.
  always_ff @(posedge clk1khz) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_clr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BW'(1);
    end
  end

  // Idle timer: cleared on demand, otherwise counts up and holds at its last value.
  always_ff @(posedge clk1khz) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (idle_clr) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_LAST) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign idle_max = (idle_cnt == IDLE_LAST);

endmodule

// File: rtl/disp_mode_scheduler.sv
// rtl/disp_mode_scheduler.sv - display mode FSM and dispnum mux; DISP_LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit
module disp_mode_scheduler
  import disp_pkg::*;
#(
  parameter int unsigned BLINK_HALF_MS   = 250,
  parameter int unsigned IDLE_TIMEOUT_MS = 10000
) (
  input  logic        clk1khz,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_activity,
  input  logic [23:0] time_bcd,
  input  logic [23:0] date_bcd,
  input  logic [23:0] alarm_bcd,
  input  logic [23:0] swatch_bcd,
  input  logic        edit_en,
  input  logic [1:0]  edit_field,
  input  logic        alarm_ring,
  output logic [23:0] dispnum,
  output logic [2:0]  mode,
  output logic        blink_phase,
  output logic        ring_ack
);

  mode_t       state, state_nxt;
  logic        key_mode_d, ring_d;
  logic [1:0]  edit_field_d;
  logic        mode_edge, ring_rise, ring_fall, ring_evt;
  logic        idle_max, timeout, idle_clr, blink_clr, ack_nxt;
  logic        edit_mode;
  logic [23:0] disp_nxt;

  assign mode_edge = key_mode & ~key_mode_d;
  assign ring_rise = alarm_ring & ~ring_d;
  assign ring_fall = ~alarm_ring & ring_d & (state == MODE_RING);
  assign ring_evt  = ring_rise | ring_fall;
  assign edit_mode = (state == MODE_TIME) || (state == MODE_ALARM);

  // A timeout only fires when nothing of higher priority or any key activity shares the cycle.
  assign timeout   = idle_max & ~key_activity & ~edit_en & ~ring_evt & ~mode_edge &
                     ((state == MODE_DATE) || (state == MODE_ALARM));
  assign idle_clr  = key_activity | mode_edge | edit_en | timeout;
  assign blink_clr = (state_nxt != state) | (edit_field != edit_field_d);
  assign ack_nxt   = ~ring_evt & mode_edge & (state == MODE_RING);
  assign mode      = state;

  // Next mode: ring edges first, then the mode key, then the idle fallback.
  always_comb begin
    state_nxt = state;
    if (ring_rise) begin
      state_nxt = MODE_RING;
    end else if (ring_fall) begin
      state_nxt = MODE_TIME;
    end else if (mode_edge) begin
      case (state)
        MODE_TIME:   state_nxt = MODE_DATE;
        MODE_DATE:   state_nxt = MODE_ALARM;
        MODE_ALARM:  state_nxt = MODE_SWATCH;
        MODE_SWATCH: state_nxt = MODE_TIME;
        default:     state_nxt = state;
      endcase
    end else if (timeout) begin
      state_nxt = MODE_TIME;
    end
  end

  // Source select, optional leading-zero blank, then edit and ring blanking.
  always_comb begin
    case (state)
      MODE_TIME, MODE_RING: disp_nxt = time_bcd;
      MODE_DATE:            disp_nxt = date_bcd;
      MODE_ALARM:           disp_nxt = alarm_bcd;
      MODE_SWATCH:          disp_nxt = swatch_bcd;
      default:              disp_nxt = BLANK_ALL;
    endcase
`ifdef DISP_LEADING_ZERO_BLANK_EN
    if ((edit_mode || (state == MODE_RING)) && (disp_nxt[23:20] == 4'h0))
      disp_nxt[23:20] = BLANK_NIBBLE;
`endif
    if (edit_en && edit_mode && (edit_field != FIELD_NONE) && !blink_phase)
      disp_nxt = blank_field(disp_nxt, edit_field);
    if ((state == MODE_RING) && !blink_phase)
      disp_nxt = BLANK_ALL;
  end

  // FSM state, edge-detect history and registered outputs.
  always_ff @(posedge clk1khz) begin
    if (!rst_n) begin
      state        <= MODE_TIME;
      key_mode_d   <= key_mode;
      ring_d       <= alarm_ring;
      edit_field_d <= edit_field;
      ring_ack     <= 1'b0;
      dispnum      <= BLANK_ALL;
    end else begin
      state        <= state_nxt;
      key_mode_d   <= key_mode;
      ring_d       <= alarm_ring;
      edit_field_d <= edit_field;
      ring_ack     <= ack_nxt;
      dispnum      <= disp_nxt;
    end
  end

  disp_tick_gen #(
    .BLINK_HALF_MS  (BLINK_HALF_MS),
    .IDLE_TIMEOUT_MS(IDLE_TIMEOUT_MS)
  ) u_tick_gen (
    .clk1khz    (clk1khz),
    .rst_n      (rst_n),
    .blink_clr  (blink_clr),
    .idle_clr   (idle_clr),
    .blink_phase(blink_phase),
    .idle_max   (idle_max)
  );

endmodule

// File: tb/tb_disp_mode_scheduler.sv
// tb/tb_disp_mode_scheduler.sv - directed self-checking bench for disp_mode_scheduler
module tb_disp_mode_scheduler;

  logic        clk1khz = 1'b0;
  logic        rst_n;
  logic        key_mode;
  logic        key_activity;
  logic [23:0] time_bcd, date_bcd, alarm_bcd, swatch_bcd;
  logic        edit_en;
  logic [1:0]  edit_field;
  logic        alarm_ring;
  logic [23:0] dispnum;
  logic [2:0]  mode;
  logic        blink_phase;
  logic        ring_ack;

  int n_checks = 0;
  int n_fails  = 0;

  disp_mode_scheduler dut (
    .clk1khz     (clk1khz),
    .rst_n       (rst_n),
    .key_mode    (key_mode),
    .key_activity(key_activity),
    .time_bcd    (time_bcd),
    .date_bcd    (date_bcd),
    .alarm_bcd   (alarm_bcd),
    .swatch_bcd  (swatch_bcd),
    .edit_en     (edit_en),
    .edit_field  (edit_field),
    .alarm_ring  (alarm_ring),
    .dispnum     (dispnum),
    .mode        (mode),
    .blink_phase (blink_phase),
    .ring_ack    (ring_ack)
  );

  always #5 clk1khz = ~clk1khz;

  task automatic tick(input int n);
    repeat (n) @(posedge clk1khz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mode_step();
    key_mode = 1'b1;
    tick(1);
    key_mode = 1'b0;
    tick(1);
  endtask

  logic [23:0] exp_alarm, exp_lz;

  initial begin
`ifdef DISP_LEADING_ZERO_BLANK_EN
    exp_alarm = 24'hF63000;
    exp_lz    = 24'hF93000;
`else
    exp_alarm = 24'h063000;
    exp_lz    = 24'h093000;
`endif
    rst_n = 1'b0; key_mode = 1'b0; key_activity = 1'b0;
    time_bcd = 24'h235959; date_bcd = 24'h250101;
    alarm_bcd = 24'h063000; swatch_bcd = 24'h001234;
    edit_en = 1'b0; edit_field = 2'd3; alarm_ring = 1'b0;
    tick(2);
    chk("rst_dispnum", dispnum, 24'hFFFFFF);
    chk("rst_mode", {21'd0, mode}, 24'd0);
    chk("rst_blink", {23'd0, blink_phase}, 24'd1);
    chk("rst_ack", {23'd0, ring_ack}, 24'd0);

    rst_n = 1'b1;
    tick(1);
    chk("time_disp", dispnum, 24'h235959);

    // Mode cycling; dispnum follows one cycle after the state.
    key_mode = 1'b1; tick(1);
    chk("mode_date", {21'd0, mode}, 24'd1);
    chk("date_lag", dispnum, 24'h235959);
    key_mode = 1'b0; tick(1);
    chk("date_disp", dispnum, 24'h250101);
    key_mode = 1'b1; tick(1);
    chk("mode_alarm", {21'd0, mode}, 24'd2);
    key_mode = 1'b0; tick(1);
    chk("alarm_disp", dispnum, exp_alarm);
    key_mode = 1'b1; tick(1);
    chk("mode_swatch", {21'd0, mode}, 24'd3);
    key_mode = 1'b0; tick(1);
    chk("swatch_disp", dispnum, 24'h001234);
    key_mode = 1'b1; tick(1);
    chk("mode_time", {21'd0, mode}, 24'd0);
    key_mode = 1'b0; tick(1);
    chk("time_disp2", dispnum, 24'h235959);

    // Idle timeout from DATE lands exactly 10000 cycles after entry.
    key_mode = 1'b1; tick(1);
    key_mode = 1'b0; tick(9999);
    chk("idle_9999", {21'd0, mode}, 24'd1);
    tick(1);
    chk("idle_10000", {21'd0, mode}, 24'd0);

    // SWATCH never times out.
    mode_step(); mode_step(); mode_step();
    chk("swatch_enter", {21'd0, mode}, 24'd3);
    tick(20000);
    chk("swatch_hold", {21'd0, mode}, 24'd3);
    mode_step();
    chk("back_time", {21'd0, mode}, 24'd0);

    // Edit blink on field 1, visible half first.
    time_bcd = 24'h123456; edit_en = 1'b1; edit_field = 2'd1;
    tick(1);
    tick(1);
    chk("edit_vis_first", dispnum, 24'h123456);
    tick(249);
    chk("edit_vis_last", dispnum, 24'h123456);
    chk("edit_phase0", {23'd0, blink_phase}, 24'd0);
    tick(1);
    chk("edit_blank_first", dispnum, 24'h12FF56);
    tick(249);
    chk("edit_blank_last", dispnum, 24'h12FF56);
    tick(1);
    chk("edit_vis_again", dispnum, 24'h123456);

    // Alarm ring from ALARM mode.
    edit_en = 1'b0; edit_field = 2'd3;
    mode_step(); mode_step();
    chk("pre_ring_mode", {21'd0, mode}, 24'd2);
    alarm_ring = 1'b1; tick(1);
    chk("ring_mode", {21'd0, mode}, 24'd4);
    tick(1);
    chk("ring_vis", dispnum, 24'h123456);
    tick(250);
    chk("ring_blank", dispnum, 24'hFFFFFF);
    key_mode = 1'b1; tick(1);
    chk("ring_ack_hi", {23'd0, ring_ack}, 24'd1);
    chk("ring_stay", {21'd0, mode}, 24'd4);
    key_mode = 1'b0; tick(1);
    chk("ring_ack_lo", {23'd0, ring_ack}, 24'd0);
    alarm_ring = 1'b0; tick(1);
    chk("ring_exit", {21'd0, mode}, 24'd0);

    // Ring rise and mode edge together from DATE: ring wins.
    mode_step();
    chk("pre_coll", {21'd0, mode}, 24'd1);
    key_mode = 1'b1; alarm_ring = 1'b1; tick(1);
    chk("coll_mode", {21'd0, mode}, 24'd4);
    key_mode = 1'b0; tick(1);
    chk("coll_stay", {21'd0, mode}, 24'd4);
    chk("coll_no_ack", {23'd0, ring_ack}, 24'd0);

    // Mid-blink reset with alarm still ringing.
    tick(100);
    rst_n = 1'b0; tick(1);
    chk("mid_rst_disp", dispnum, 24'hFFFFFF);
    chk("mid_rst_mode", {21'd0, mode}, 24'd0);
    chk("mid_rst_blink", {23'd0, blink_phase}, 24'd1);
    rst_n = 1'b1; tick(1);
    chk("post_rst_mode", {21'd0, mode}, 24'd0);
    alarm_ring = 1'b0; tick(1);

    // Hour-tens zero handling.
    time_bcd = 24'h093000; tick(2);
    chk("lead_zero", dispnum, exp_lz);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
